// File: rtl/avalon_fp_mult_master.sv
// Avalon-MM master that runs the avalon_fp_mult register sequence for one operand pair.
// Optional status read-back is enabled by defining FP_MULT_MASTER_STATUS_EN.
module avalon_fp_mult_master #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_op1,
  input  logic [15:0] cmd_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_status,
  output logic        rsp_timeout,
  output logic [2:0]  avm_m1_address,
  output logic        avm_m1_write,
  output logic        avm_m1_read,
  output logic [15:0] avm_m1_writedata,
  input  logic [15:0] avm_m1_readdata,
  input  logic        avm_m1_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_OP1,
    S_WR_OP2,
    S_WR_START,
    S_RD_RES,
    S_RD_STAT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       op2_q;
  logic [2:0]        address_q;
  logic              write_q;
  logic              read_q;
  logic [15:0]       writedata_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_result_q;
  logic              rsp_timeout_q;
`ifdef FP_MULT_MASTER_STATUS_EN
  logic [2:0]        rsp_status_q;
`endif

  // Every bus output is set up one edge ahead, so each bus state drives its
  // strobe, address and data from its first cycle and holds them while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op2_q         <= '0;
      address_q     <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      writedata_q   <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
`ifdef FP_MULT_MASTER_STATUS_EN
      rsp_status_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op2_q         <= cmd_op2;
            write_q       <= 1'b1;
            address_q     <= 3'd0;
            writedata_q   <= cmd_op1;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
`ifdef FP_MULT_MASTER_STATUS_EN
            rsp_status_q  <= '0;
`endif
            state_q       <= S_WR_OP1;
          end
        end

        S_WR_OP1, S_WR_OP2, S_WR_START, S_RD_RES, S_RD_STAT: begin
          if (avm_m1_waitrequest) begin
            // A transfer stalled for TIMEOUT counted cycles is abandoned outright.
            if (cnt_q == TIMEOUT_C) begin
              write_q       <= 1'b0;
              read_q        <= 1'b0;
              address_q     <= '0;
              writedata_q   <= '0;
              rsp_result_q  <= '0;
              rsp_timeout_q <= 1'b1;
              rsp_valid_q   <= 1'b1;
`ifdef FP_MULT_MASTER_STATUS_EN
              rsp_status_q  <= '0;
`endif
              state_q       <= S_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
            case (state_q)
              S_WR_OP1: begin
                address_q   <= 3'd1;
                writedata_q <= op2_q;
                state_q     <= S_WR_OP2;
              end
              S_WR_OP2: begin
                address_q   <= 3'd2;
                writedata_q <= 16'h0001;
                state_q     <= S_WR_START;
              end
              S_WR_START: begin
                write_q     <= 1'b0;
                read_q      <= 1'b1;
                address_q   <= 3'd3;
                writedata_q <= '0;
                state_q     <= S_RD_RES;
              end
              S_RD_RES: begin
                rsp_result_q <= avm_m1_readdata;
`ifdef FP_MULT_MASTER_STATUS_EN
                address_q    <= 3'd4;
                state_q      <= S_RD_STAT;
`else
                read_q       <= 1'b0;
                address_q    <= '0;
                rsp_valid_q  <= 1'b1;
                state_q      <= S_DONE;
`endif
              end
              S_RD_STAT: begin
`ifdef FP_MULT_MASTER_STATUS_EN
                rsp_status_q <= avm_m1_readdata[2:0];
`endif
                read_q       <= 1'b0;
                address_q    <= '0;
                rsp_valid_q  <= 1'b1;
                state_q      <= S_DONE;
              end
              default: begin
              end
            endcase
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_result       = rsp_result_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign avm_m1_address   = address_q;
  assign avm_m1_write     = write_q;
  assign avm_m1_read      = read_q;
  assign avm_m1_writedata = writedata_q;
`ifdef FP_MULT_MASTER_STATUS_EN
  assign rsp_status       = rsp_status_q;
`else
  assign rsp_status       = 3'b000;
`endif

endmodule

// File: tb/tb_avalon_fp_mult_master.sv
// Scoreboard bench for avalon_fp_mult_master against a configurable-stall Avalon slave model.
module tb_avalon_fp_mult_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_op1;
  logic [15:0] cmd_op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_status;
  logic        rsp_timeout;
  logic [2:0]  avm_m1_address;
  logic        avm_m1_write;
  logic        avm_m1_read;
  logic [15:0] avm_m1_writedata;
  logic [15:0] avm_m1_readdata;
  logic        avm_m1_waitrequest;

  avalon_fp_mult_master #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .avm_m1_address(avm_m1_address), .avm_m1_write(avm_m1_write), .avm_m1_read(avm_m1_read),
    .avm_m1_writedata(avm_m1_writedata), .avm_m1_readdata(avm_m1_readdata),
    .avm_m1_waitrequest(avm_m1_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isWrite;
    logic [2:0]  addr;
    logic [15:0] data;
  } busExp_t;

  typedef struct {
    logic [15:0] result;
    logic [2:0]  status;
    bit          timedOut;
    int          latency;
    int          rdRun;
    int          rdyDelay;
  } rspExp_t;

  busExp_t     expBus[$];
  rspExp_t     expRsp[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          waitCfg [8];
  logic [15:0] rdData [8];
  int          stallCnt = 0;
  bit          started = 0;
  int          acceptCyc = 0;
  int          hsCyc = 0;
  int          rspDone = 0;
  int          rspTarget = 0;

  // Slave model: each address stalls for waitCfg[addr] cycles before accepting
  assign avm_m1_waitrequest = (avm_m1_read || avm_m1_write) && (stallCnt < waitCfg[avm_m1_address]);
  assign avm_m1_readdata    = avm_m1_read ? rdData[avm_m1_address] : 16'h0000;

  always @(posedge clk) begin
    if (avm_m1_waitrequest) stallCnt <= stallCnt + 1;
    else                    stallCnt <= 0;
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] op1, input logic [15:0] op2,
                               input logic [15:0] res, input logic [2:0] stat,
                               input int w0, input int w1, input int w2, input int w3, input int w4,
                               input int rdy, input bit toExp);
    rspExp_t r;
    int lat;
    waitCfg[0] = w0; waitCfg[1] = w1; waitCfg[2] = w2; waitCfg[3] = w3; waitCfg[4] = w4;
    rdData[3] = res;
    rdData[4] = {13'h0A5A, stat};
    expBus.push_back('{1'b1, 3'd0, op1});
    expBus.push_back('{1'b1, 3'd1, op2});
    expBus.push_back('{1'b1, 3'd2, 16'h0001});
    if (!toExp) begin
      expBus.push_back('{1'b0, 3'd3, 16'h0000});
`ifdef FP_MULT_MASTER_STATUS_EN
      expBus.push_back('{1'b0, 3'd4, 16'h0000});
`endif
    end
    lat = 1 + (1 + w0) + (1 + w1) + (1 + w2) + (toExp ? TO + 1 : 1 + w3);
    r.status = 3'd0;
`ifdef FP_MULT_MASTER_STATUS_EN
    if (!toExp) begin
      lat = lat + 1 + w4;
      r.status = stat;
    end
`endif
    r.result   = toExp ? 16'h0000 : res;
    r.timedOut = toExp;
    r.latency  = lat;
    r.rdRun    = toExp ? TO + 1 : 1 + w3;
    r.rdyDelay = rdy;
    expRsp.push_back(r);
    cmd_op1   = op1;
    cmd_op2   = op2;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
    checkOutput("cmd_accept", cmd_ready, 1);
    acceptCyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op1   = 16'hDEAD;
    cmd_op2   = 16'hBEEF;
  endtask

  task automatic waitRsp();
    rspTarget++;
    for (int i = 0; i < 400 && rspDone < rspTarget; i++) @(negedge clk);
    checkOutput("rsp_done", rspDone, rspTarget);
    checkOutput("bus_left", expBus.size(), 0);
  endtask

  // Bus and response monitor; also plays the response consumer
  logic [35:0] prevBus;
  bit          prevStall = 0;
  bit          prevValid = 0;
  bit          hsPending = 0;
  int          runLen = 0;
  int          lastRun = 0;
  int          holdCnt = 0;
  int          curDelay = 0;
  logic [19:0] heldRsp;
  busExp_t     eb;
  rspExp_t     er;

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("rw_excl", avm_m1_read && avm_m1_write, 0);
        if (!(avm_m1_read || avm_m1_write))
          checkOutput("idle_bus", {avm_m1_address, avm_m1_writedata}, 0);
        if (prevStall && (avm_m1_read || avm_m1_write))
          checkOutput("stall_hold", {avm_m1_write, avm_m1_read, avm_m1_address, avm_m1_writedata}, prevBus);
        if ((avm_m1_read || avm_m1_write) && !avm_m1_waitrequest) begin
          checkOutput("bus_pending", expBus.size() != 0, 1);
          if (expBus.size() != 0) begin
            eb = expBus.pop_front();
            checkOutput("bus_kind", {avm_m1_write, avm_m1_read}, eb.isWrite ? 2'b10 : 2'b01);
            checkOutput("bus_addr", avm_m1_address, eb.addr);
            if (eb.isWrite) checkOutput("bus_wdata", avm_m1_writedata, eb.data);
          end
        end
        if (avm_m1_read && avm_m1_address == 3'd3) runLen++;
        else if (runLen != 0) begin
          lastRun = runLen;
          runLen  = 0;
        end
        prevStall = (avm_m1_read || avm_m1_write) && avm_m1_waitrequest;
        prevBus   = {avm_m1_write, avm_m1_read, avm_m1_address, avm_m1_writedata};

        if (hsPending) begin
          checkOutput("after_hs", {rsp_valid, cmd_ready}, 2'b01);
          hsPending = 0;
          rsp_ready = 1'b0;
          rspDone++;
        end else if (rsp_valid) begin
          if (!prevValid) begin
            checkOutput("rsp_pending", expRsp.size(), 1);
            if (expRsp.size() != 0) begin
              er = expRsp.pop_front();
              checkOutput("rsp_latency", cyc - acceptCyc, er.latency);
              checkOutput("rsp_result", rsp_result, er.result);
              checkOutput("rsp_status", rsp_status, er.status);
              checkOutput("rsp_timeout", rsp_timeout, er.timedOut);
              checkOutput("rd_res_cycles", lastRun, er.rdRun);
              curDelay = er.rdyDelay;
            end
            holdCnt = 0;
            heldRsp = {rsp_result, rsp_status, rsp_timeout};
          end else begin
            checkOutput("rsp_stable", {rsp_result, rsp_status, rsp_timeout}, heldRsp);
            checkOutput("cmd_ready_done", cmd_ready, 0);
          end
          if (holdCnt >= curDelay) begin
            rsp_ready = 1'b1;
            hsPending = 1;
            hsCyc     = cyc;
          end
          holdCnt++;
        end
        prevValid = rsp_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op1   = 16'h0000;
    cmd_op2   = 16'h0000;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      waitCfg[i] = 0;
      rdData[i]  = 16'h0000;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_state",
                {cmd_ready, rsp_valid, rsp_result, rsp_status, rsp_timeout,
                 avm_m1_address, avm_m1_write, avm_m1_read, avm_m1_writedata},
                {1'b1, 42'b0});
    reset   = 1'b0;
    started = 1;

    // Zero-wait slave, 1.5 x 2.0
    applyStimulus(16'h3FC0, 16'h4000, 16'h4040, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0);
    waitRsp();
    // Peripheral-like timing: result read stalls three cycles
    applyStimulus(16'h3FC0, 16'h4000, 16'h4040, 3'd0, 0, 0, 0, 3, 0, 0, 1'b0);
    waitRsp();
    applyStimulus(16'h0000, 16'h4000, 16'h0000, 3'd3, 0, 0, 0, 3, 0, 1, 1'b0);
    waitRsp();

    for (int n = 0; n < 5; n++) begin
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 4)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      waitRsp();
    end

    // Result read never completes; response held 5 cycles; next command queued during DONE
    applyStimulus(16'h1111, 16'h2222, 16'h7777, 3'd1, 0, 0, 0, 255, 0, 5, 1'b1);
    for (int i = 0; i < 400 && !rsp_valid; i++) @(negedge clk);
    @(negedge clk);
    applyStimulus(16'h4049, 16'h3F80, 16'h4049, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput("accept_after_hs", acceptCyc, hsCyc + 1);
    rspTarget++;
    waitRsp();

    // Reset pulsed while the op2 write is stalled
    waitCfg[0] = 0;
    waitCfg[1] = 6;
    expBus.push_back('{1'b1, 3'd0, 16'h1234});
    cmd_op1   = 16'h1234;
    cmd_op2   = 16'h5678;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && !(avm_m1_write && avm_m1_address == 3'd1 && avm_m1_waitrequest); i++)
      @(negedge clk);
    checkOutput("op2_stall", {avm_m1_write, avm_m1_address, avm_m1_waitrequest}, {1'b1, 3'd1, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_reset", {avm_m1_write, cmd_ready, rsp_valid}, 3'b010);
    checkOutput("reset_bus_left", expBus.size(), 0);

    applyStimulus(16'hC000, 16'h4000, 16'hC080, 3'd0, 1, 0, 2, 3, 1, 0, 1'b0);
    waitRsp();

    checkOutput("rsp_left", expRsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_fp_mult_master.md
# avalon_fp_mult_master

Avalon-MM master sequencer that drives the `avalon_fp_mult` peripheral on behalf of a datapath client. It accepts one operand pair on a valid/ready command port and runs the full peripheral register sequence: write op1, write op2, write start, read result, read status. All bus transfers honour `waitrequest`. It returns the bfloat16 product and status on a valid/ready response port. It sits between the pipelined processor's FP issue logic and the Avalon interconnect.

## Interface
Parameters:
- `TIMEOUT`, 64: consecutive `waitrequest` cycles on one transfer before the master aborts; must be ≥1.
- `CNT_W`, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: operand pair is present.
- `cmd_ready` out 1: master is idle and can accept a command.
- `cmd_op1` in 16: first bfloat16 operand.
- `cmd_op2` in 16: second bfloat16 operand.
- `rsp_valid` out 1: response is present.
- `rsp_ready` in 1: client accepts the response.
- `rsp_result` out 16: product read back from address 3.
- `rsp_status` out 3: status read back from address 4 (0 ok, 1 ovf, 2 unf, 3 zero, 4 nan).
- `rsp_timeout` out 1: the transaction was aborted.
- `avm_m1_address` out 3: register address.
- `avm_m1_write` out 1: write request.
- `avm_m1_read` out 1: read request.
- `avm_m1_writedata` out 16: write data.
- `avm_m1_readdata` in 16: read data; valid when `read && !waitrequest`.
- `avm_m1_waitrequest` in 1: slave stall.

## Operation
- States:
  - IDLE: `cmd_ready=1`. On `cmd_valid`, latch both operands and go to WR_OP1.
  - WR_OP1: drive `write=1`, addr 0, data op1.
  - WR_OP2: drive `write=1`, addr 1, data op2.
  - WR_START: drive `write=1`, addr 2, data 0x0001.
  - RD_RES: drive `read=1`, addr 3. Capture readdata into `rsp_result`.
  - RD_STAT: drive `read=1`, addr 4. Capture `readdata[2:0]` into `rsp_status`.
  - DONE: `rsp_valid=1`. On `rsp_ready`, go to IDLE.
- Each bus state advances only in a cycle where `avm_m1_waitrequest=0`. While stalled, address, data and the request strobe are held stable.
- Read and write are never asserted together. Both are 0 in IDLE and DONE. Address and writedata are 0 whenever no request is driven.
- Wait counter:
  - Cleared on entry to every bus state.
  - Increments each cycle the current transfer sees `waitrequest=1`.
  - When the counter equals TIMEOUT and waitrequest is still 1: drop the request, go to DONE with `rsp_timeout=1`, `rsp_result=0`, `rsp_status=0`.
- Response fields stay stable from DONE entry until the handshake. `rsp_timeout` is cleared when the next command is accepted.
- There is no command queue. `cmd_valid` outside IDLE is ignored.

## Timing
- Reset (synchronous): state IDLE. After the edge, all outputs are 0 except `cmd_ready=1`. Counter is cleared.
- Reset asserted mid-transaction: the next edge forces IDLE. The in-flight request is dropped without completion and nothing is reported.
- Command accepted at edge of cycle 0. Bus states then run in cycles 1, 2, 3, 4, 5, each lasting 1 + its waitrequest cycles.
- Latency against a zero-wait slave: `rsp_valid` in cycle 6.
- Latency against `avalon_fp_mult`: RD_RES stalls 3 cycles (cycles 4–7), RD_STAT is cycle 8, `rsp_valid` in cycle 9.
- A DONE→IDLE handshake in cycle N makes `cmd_ready=1` in cycle N+1. There is no same-cycle reuse.
- Timeout: with waitrequest high from the first cycle of a transfer, the abort edge is the end of that transfer's (TIMEOUT+1)th cycle.

## Configuration
- `FP_MULT_MASTER_STATUS_EN` defined: the RD_STAT state is present and `rsp_status` carries the peripheral status.
- Not defined: RD_RES goes directly to DONE and `rsp_status` is tied to 0. Latency is one cycle shorter: cycle 5 against a zero-wait slave, cycle 8 against the peripheral.

## Test plan
- Zero-wait slave model, op1=0x3FC0, op2=0x4000, slave returns 0x4040 then 0x0000:
  - Bus carries writes (0,0x3FC0), (1,0x4000), (2,0x0001), then reads 3 and 4.
  - Response: `rsp_valid` in cycle 6, result 0x4040, status 0.
- Real `avalon_fp_mult`, 1.5×2.0 (0x3FC0×0x4000) → result 0x4040, status 0, `rsp_valid` in cycle 9. Strobes and address are held during the 3 stall cycles.
- Real peripheral, 0x0000×0x4000 → result 0x0000, status 3.
- TIMEOUT=8, slave holds waitrequest in RD_RES → `read` drops after the 9th RD_RES cycle. Response: `rsp_valid`, `rsp_timeout=1`, result 0.
- `rsp_ready` held low 5 cycles in DONE:
  - Response fields stay stable and `cmd_ready=0` throughout.
  - Second command is accepted the cycle after the handshake; `rsp_timeout` is 0 for it.
- `reset` pulsed during WR_OP2 stall → next cycle `write=0`, `cmd_ready=1`, `rsp_valid=0`. A fresh command then completes normally.
